// File: rtl/pipeline_pkg.sv
// Shared opcode, function-code and FSM encodings for the ID/EX hazard logic.
package pipeline_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_RTYPE = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BLT   = 4'b0101;
  localparam logic [3:0] OP_BGT   = 4'b0110;
  localparam logic [3:0] OP_LOAD  = 4'b1000;

  localparam logic [3:0] FC_ADD   = 4'b0000;
  localparam logic [3:0] FC_MUL   = 4'b0100;
  localparam logic [3:0] FC_DIV   = 4'b0101;
  localparam logic [3:0] FC_SWAP  = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_BR2 = 2'd1,
    ST_MD  = 2'd2
  } state_e;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGT);
  endfunction

  // True when the ID instruction reads register r (R0 included, no hardwired zero).
  function automatic logic id_reads(input logic [3:0] r, input logic [3:0] op1,
                                    input logic [3:0] op2, input logic uses_op2);
    return (op1 == r) || (uses_op2 && (op2 == r));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush control for load-use, branch-on-load, taken-branch and MUL/DIV
// occupancy hazards that operand forwarding cannot resolve.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_opcode,
  input  logic [3:0]       id_op1,
  input  logic [3:0]       id_op2,
  input  logic             id_uses_op2,
  input  logic [3:0]       ex_opcode,
  input  logic [3:0]       ex_funct,
  input  logic [3:0]       ex_dest,
  input  logic [3:0]       mem_opcode,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic             exmem_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 2);

  state_e          state, state_nxt;
  logic [MD_W-1:0] md_cnt, md_cnt_nxt;

  logic load_use;
  logic is_md;
  logic br2_hit;

  assign load_use = (ex_opcode == OP_LOAD) && id_reads(ex_dest, id_op1, id_op2, id_uses_op2);
  assign is_md    = (ex_opcode == OP_RTYPE) && ((ex_funct == FC_MUL) || (ex_funct == FC_DIV));
  // The load that triggered BR2 has moved to MEM; only stall if it is still there.
  assign br2_hit  = (mem_opcode == OP_LOAD) && id_reads(mem_dest, id_op1, id_op2, id_uses_op2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;

    if (rst) begin
      state_nxt  = ST_RUN;
      md_cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (is_md) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ex_hold      = 1'b1;
            exmem_bubble = 1'b1;
            md_cnt_nxt   = MD_LOAD;
            state_nxt    = ST_MD;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (is_branch(id_opcode)) begin
              state_nxt = ST_BR2;
            end
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end

        ST_BR2: begin
          state_nxt = ST_RUN;
          if (br2_hit) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end

        ST_MD: begin
          // Last count releases EX so the result reaches EX/MEM on the next edge.
          if (md_cnt == '0) begin
            state_nxt = ST_RUN;
            if (branch_taken) begin
              ifid_flush = 1'b1;
            end
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ex_hold      = 1'b1;
            exmem_bubble = 1'b1;
            md_cnt_nxt   = md_cnt - MD_W'(1);
          end
        end

        default: begin
          state_nxt  = ST_RUN;
          md_cnt_nxt = '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: single-cycle vector table plus
// multi-cycle load-use, branch-on-load, flush, MUL/DIV, reset and saturation sequences.
module tb_hazard_stall_controller;
  import pipeline_pkg::*;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [3:0]       id_opcode, id_op1, id_op2;
  logic             id_uses_op2;
  logic [3:0]       ex_opcode, ex_funct, ex_dest;
  logic [3:0]       mem_opcode, mem_dest;
  logic             branch_taken;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [5:0]       ctl;

  int total = 0;
  int bad   = 0;

  hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_opcode    (id_opcode),
    .id_op1       (id_op1),
    .id_op2       (id_op2),
    .id_uses_op2  (id_uses_op2),
    .ex_opcode    (ex_opcode),
    .ex_funct     (ex_funct),
    .ex_dest      (ex_dest),
    .mem_opcode   (mem_opcode),
    .mem_dest     (mem_dest),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .ex_hold      (ex_hold),
    .exmem_bubble (exmem_bubble),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble}
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble};

  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_LU    = 6'b000100;
  localparam logic [5:0] C_MD    = 6'b000011;
  localparam logic [5:0] C_FLUSH = 6'b111000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_v;
    logic [3:0] id_opc;
    logic [3:0] op1;
    logic [3:0] op2;
    logic       uses2;
    logic [3:0] ex_opc;
    logic [3:0] funct;
    logic [3:0] dest;
    logic       taken;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic r, input logic [3:0] io, input logic [3:0] a,
                              input logic [3:0] b, input logic u, input logic [3:0] eo,
                              input logic [3:0] f, input logic [3:0] d, input logic t,
                              input logic [5:0] e);
    vec_t v;
    v.rst_v = r; v.id_opc = io; v.op1 = a; v.op2 = b; v.uses2 = u;
    v.ex_opc = eo; v.funct = f; v.dest = d; v.taken = t; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_nop();
    id_opcode = OP_NOP; id_op1 = 4'd1; id_op2 = 4'd1; id_uses_op2 = 1'b0;
    ex_opcode = OP_NOP; ex_funct = FC_ADD; ex_dest = 4'd15;
    mem_opcode = OP_NOP; mem_dest = 4'd15; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_nop();
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_nop();

    vt[0]  = mk(0, OP_NOP,   1, 1, 0, OP_NOP,   FC_ADD,  15, 0, C_RUN);
    vt[1]  = mk(0, OP_RTYPE, 3, 5, 1, OP_LOAD,  FC_ADD,  3,  0, C_LU);
    vt[2]  = mk(0, OP_RTYPE, 1, 3, 1, OP_LOAD,  FC_ADD,  3,  0, C_LU);
    vt[3]  = mk(0, OP_ADDI,  1, 3, 0, OP_LOAD,  FC_ADD,  3,  0, C_RUN);
    vt[4]  = mk(0, OP_RTYPE, 0, 7, 1, OP_LOAD,  FC_ADD,  0,  0, C_LU);
    vt[5]  = mk(0, OP_RTYPE, 1, 2, 1, OP_RTYPE, FC_MUL,  9,  0, C_MD);
    vt[6]  = mk(0, OP_RTYPE, 1, 2, 1, OP_RTYPE, FC_DIV,  9,  0, C_MD);
    vt[7]  = mk(0, OP_RTYPE, 1, 2, 1, OP_RTYPE, FC_SWAP, 9,  0, C_RUN);
    vt[8]  = mk(0, OP_BEQ,   2, 6, 1, OP_RTYPE, FC_ADD,  2,  1, C_FLUSH);
    vt[9]  = mk(0, OP_BEQ,   2, 6, 1, OP_LOAD,  FC_ADD,  6,  1, C_LU);
    vt[10] = mk(0, OP_BEQ,   2, 6, 1, OP_RTYPE, FC_MUL,  2,  1, C_MD);
    vt[11] = mk(0, OP_RTYPE, 1, 2, 1, OP_ADDI,  FC_MUL,  9,  0, C_RUN);
    vt[12] = mk(1, OP_RTYPE, 3, 5, 1, OP_LOAD,  FC_ADD,  3,  1, C_RUN);

    // Reset state
    #1;
    chk("reset_ctl", 32'(ctl), 32'(C_RUN));
    chk("reset_stall", 32'(stall_cycles), 0);
    chk("reset_flush", 32'(flush_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle decisions from RUN
    for (int i = 0; i < 13; i++) begin
      do_reset();
      rst          = vt[i].rst_v;
      id_opcode    = vt[i].id_opc;
      id_op1       = vt[i].op1;
      id_op2       = vt[i].op2;
      id_uses_op2  = vt[i].uses2;
      ex_opcode    = vt[i].ex_opc;
      ex_funct     = vt[i].funct;
      ex_dest      = vt[i].dest;
      branch_taken = vt[i].taken;
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vt[i].exp));
      rst = 1'b0;
    end

    // Load-use: one bubble then advance
    do_reset();
    ex_opcode = OP_LOAD; ex_dest = 4'd3;
    id_opcode = OP_RTYPE; id_op1 = 4'd3; id_op2 = 4'd5; id_uses_op2 = 1'b1;
    #1 chk("lu_c0", 32'(ctl), 32'(C_LU));
    @(negedge clk);
    ex_opcode = OP_NOP; mem_opcode = OP_LOAD; mem_dest = 4'd3;
    #1 chk("lu_c1", 32'(ctl), 32'(C_RUN));
    @(negedge clk);
    set_nop();
    #1 chk("lu_stall", 32'(stall_cycles), 1);

    // Branch on load: two bubbles, then the branch resolves and flushes
    do_reset();
    ex_opcode = OP_LOAD; ex_dest = 4'd2;
    id_opcode = OP_BEQ; id_op1 = 4'd2; id_op2 = 4'd6; id_uses_op2 = 1'b1;
    #1 chk("bl_c0", 32'(ctl), 32'(C_LU));
    @(negedge clk);
    ex_opcode = OP_NOP; mem_opcode = OP_LOAD; mem_dest = 4'd2; branch_taken = 1'b1;
    #1 chk("bl_c1", 32'(ctl), 32'(C_LU));
    @(negedge clk);
    mem_opcode = OP_NOP;
    #1 chk("bl_c2", 32'(ctl), 32'(C_FLUSH));
    @(negedge clk);
    set_nop();
    #1;
    chk("bl_stall", 32'(stall_cycles), 2);
    chk("bl_flush", 32'(flush_count), 1);

    // BR2 with the load gone from MEM: no second stall
    do_reset();
    ex_opcode = OP_LOAD; ex_dest = 4'd2;
    id_opcode = OP_BLT; id_op1 = 4'd2; id_op2 = 4'd6; id_uses_op2 = 1'b1;
    @(negedge clk);
    ex_opcode = OP_NOP; mem_opcode = OP_RTYPE; mem_dest = 4'd2;
    #1 chk("br2_nohit", 32'(ctl), 32'(C_RUN));

    // ALU producer then taken branch: flush only
    do_reset();
    ex_opcode = OP_RTYPE; ex_funct = FC_ADD; ex_dest = 4'd2;
    id_opcode = OP_BEQ; id_op1 = 4'd2; id_op2 = 4'd6; id_uses_op2 = 1'b1; branch_taken = 1'b1;
    #1 chk("br_c0", 32'(ctl), 32'(C_FLUSH));
    @(negedge clk);
    set_nop();
    #1;
    chk("br_flush", 32'(flush_count), 1);
    chk("br_stall", 32'(stall_cycles), 0);

    // MUL: three hold cycles, release on the fourth
    do_reset();
    ex_opcode = OP_RTYPE; ex_funct = FC_MUL; ex_dest = 4'd7;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("md_c%0d", c), 32'(ctl), (c < 3) ? 32'(C_MD) : 32'(C_RUN));
      @(negedge clk);
    end
    set_nop();
    #1;
    chk("md_stall", 32'(stall_cycles), 3);
    chk("md_state", 32'(dut.state), 32'(ST_RUN));

    // Reset in the second MD cycle
    do_reset();
    ex_opcode = OP_RTYPE; ex_funct = FC_DIV; ex_dest = 4'd7;
    @(negedge clk);
    #1 chk("rmd_hold", 32'(ctl), 32'(C_MD));
    rst = 1'b1;
    #1;
    chk("rmd_ctl", 32'(ctl), 32'(C_RUN));
    chk("rmd_state", 32'(dut.state), 32'(ST_RUN));
    chk("rmd_stall", 32'(stall_cycles), 0);
    chk("rmd_flush", 32'(flush_count), 0);
    @(negedge clk);
    rst = 1'b0;
    set_nop();
    #1 chk("rmd_after", 32'(ctl), 32'(C_RUN));

    // Saturation: 2^16+5 stall cycles
    do_reset();
    ex_opcode = OP_LOAD; ex_dest = 4'd3;
    id_opcode = OP_RTYPE; id_op1 = 4'd3; id_uses_op2 = 1'b0;
    repeat (65534) @(negedge clk);
    #1 chk("sat_pre", 32'(stall_cycles), 32'hFFFE);
    repeat (1) @(negedge clk);
    #1 chk("sat_full", 32'(stall_cycles), 32'hFFFF);
    repeat (6) @(negedge clk);
    #1 chk("sat_hold", 32'(stall_cycles), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
